// File: rtl/io_channel_ready_gen_pkg.sv
// Shared definitions for the I/O channel ready generator: the address
// region constants, the FSM state encoding and the region classifier.
package io_channel_ready_gen_pkg;

    localparam logic [2:0] VID_BASE_HI = 3'b101;
    localparam logic [3:0] ROM_BASE_HI = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EXT  = 2'd2,
        HOLD = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        REGION_NONE = 2'd0,
        REGION_VID  = 2'd1,
        REGION_ROM  = 2'd2
    } region_t;

    // Video takes precedence over ROM; the two ranges do not overlap anyway.
    function automatic region_t classify_region(input logic [19:0] addr);
        region_t region;
        if (addr[19:17] == VID_BASE_HI) begin
            region = REGION_VID;
        end else if (addr[19:16] == ROM_BASE_HI) begin
            region = REGION_ROM;
        end else begin
            region = REGION_NONE;
        end
        return region;
    endfunction

endpackage

// File: rtl/io_channel_ready_gen_if.sv
// CPU bus strobes/address in, chipset ready/check out.
interface io_channel_ready_gen_if;
    logic [19:0] address;
    logic        io_read_n;
    logic        io_write_n;
    logic        memory_read_n;
    logic        memory_write_n;
    logic        address_enable_n;
    logic        turbo;
    logic        ext_ready;
    logic        check_clear;
    logic        io_channel_ready;
    logic        io_channel_check;

    modport master (
        output address, io_read_n, io_write_n, memory_read_n, memory_write_n,
               address_enable_n, turbo, ext_ready, check_clear,
        input  io_channel_ready, io_channel_check
    );

    modport slave (
        input  address, io_read_n, io_write_n, memory_read_n, memory_write_n,
               address_enable_n, turbo, ext_ready, check_clear,
        output io_channel_ready, io_channel_check
    );
endinterface

// File: rtl/io_channel_ready_gen_wait_counter.sv
// Loadable saturating counter. up=0: down-counter toward zero; up=1: up-counter
// toward all-ones. terminal flags count == limit.
module io_channel_ready_gen_wait_counter #(
    parameter int CW = 10
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    input  logic          enable,
    input  logic          up,
    input  logic [CW-1:0] limit,
    output logic          terminal
);

    logic [CW-1:0] count_r;

    // Counter register: clear beats load beats count; never wraps.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {CW{1'b0}};
        end else if (clear) begin
            count_r <= {CW{1'b0}};
        end else if (load) begin
            count_r <= load_value;
        end else if (enable) begin
            if (up) begin
                if (count_r != {CW{1'b1}}) begin
                    count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    count_r <= count_r;
                end
            end else begin
                if (count_r != {CW{1'b0}}) begin
                    count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    count_r <= count_r;
                end
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign terminal = (count_r == limit);

endmodule

// File: rtl/io_channel_ready_gen.sv
// Wait-state generator for the chipset READY stage: stretches I/O, video and
// ROM cycles by a programmed number of clocks, then follows ext_ready with a
// timeout that raises a sticky I/O channel check.
module io_channel_ready_gen #(
    parameter int IO_WAITS    = 4,
    parameter int VID_WAITS   = 2,
    parameter int ROM_WAITS   = 1,
    parameter int TURBO_EXTRA = 1,
    parameter int TIMEOUT     = 1023,
    parameter int CW          = 10
) (
    input  logic                  clock,
    input  logic                  reset_n,
    io_channel_ready_gen_if.slave bus
);
    import io_channel_ready_gen_pkg::*;

    state_t        state_r, state_nx_s;
    logic          ready_r, ready_nx_s;
    logic          check_r, check_set_s;
    logic          prev_any_strobe_r;
    logic          any_strobe_s, start_s, io_cycle_s;
    logic [CW-1:0] base_waits_s, n_waits_s;
    logic          cnt_load_s, cnt_en_s, cnt_clr_s, cnt_term_s;
    logic          tmo_en_s, tmo_clr_s, tmo_term_s;

    assign any_strobe_s = bus.io_read_n & bus.io_write_n &
                          bus.memory_read_n & bus.memory_write_n;
    assign start_s      = ~any_strobe_s & prev_any_strobe_r;
    assign io_cycle_s   = ~bus.io_read_n | ~bus.io_write_n;

    // Wait count for the cycle that starts this clock; DMA owns the bus so no stretch.
    always_comb begin
        base_waits_s = {CW{1'b0}};
        n_waits_s    = {CW{1'b0}};
        if (io_cycle_s) begin
            base_waits_s = CW'(IO_WAITS);
        end else begin
            case (classify_region(bus.address))
                REGION_VID: base_waits_s = CW'(VID_WAITS);
                REGION_ROM: base_waits_s = CW'(ROM_WAITS);
                default:    base_waits_s = {CW{1'b0}};
            endcase
        end
        if (!bus.address_enable_n) begin
            n_waits_s = {CW{1'b0}};
        end else if ((base_waits_s != {CW{1'b0}}) && bus.turbo) begin
            n_waits_s = base_waits_s + CW'(TURBO_EXTRA);
        end else begin
            n_waits_s = base_waits_s;
        end
    end

    // Fixed wait-state down-counter; terminal at 1 so ready is low exactly N clocks.
    io_channel_ready_gen_wait_counter #(.CW(CW)) u_cnt (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (cnt_clr_s),
        .load       (cnt_load_s),
        .load_value (n_waits_s),
        .enable     (cnt_en_s),
        .up         (1'b0),
        .limit      ({{(CW-1){1'b0}}, 1'b1}),
        .terminal   (cnt_term_s)
    );

    // ext_ready timeout up-counter; terminal one short so the release lands on the TIMEOUT-th low clock.
    io_channel_ready_gen_wait_counter #(.CW(CW)) u_tmo (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (tmo_clr_s),
        .load       (1'b0),
        .load_value ({CW{1'b0}}),
        .enable     (tmo_en_s),
        .up         (1'b1),
        .limit      (CW'(TIMEOUT - 1)),
        .terminal   (tmo_term_s)
    );

    // Next-state and next-output decode for the cycle FSM.
    always_comb begin
        state_nx_s  = state_r;
        ready_nx_s  = ready_r;
        check_set_s = 1'b0;
        cnt_load_s  = 1'b0;
        cnt_en_s    = 1'b0;
        cnt_clr_s   = 1'b0;
        tmo_en_s    = 1'b0;
        tmo_clr_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_s && (n_waits_s != {CW{1'b0}})) begin
                    state_nx_s = WAIT;
                    ready_nx_s = 1'b0;
                    cnt_load_s = 1'b1;
                end else if (start_s) begin
                    state_nx_s = EXT;
                    ready_nx_s = bus.ext_ready;
                end else begin
                    ready_nx_s = 1'b1;
                end
            end
            WAIT: begin
                if (any_strobe_s) begin
                    state_nx_s = IDLE;
                    ready_nx_s = 1'b1;
                    cnt_clr_s  = 1'b1;
                    tmo_clr_s  = 1'b1;
                end else if (cnt_term_s) begin
                    state_nx_s = EXT;
                    ready_nx_s = bus.ext_ready;
                    cnt_clr_s  = 1'b1;
                end else begin
                    ready_nx_s = 1'b0;
                    cnt_en_s   = 1'b1;
                end
            end
            EXT: begin
                if (any_strobe_s) begin
                    state_nx_s = IDLE;
                    ready_nx_s = 1'b1;
                    cnt_clr_s  = 1'b1;
                    tmo_clr_s  = 1'b1;
                end else if (bus.ext_ready) begin
                    state_nx_s = HOLD;
                    ready_nx_s = 1'b1;
                    tmo_clr_s  = 1'b1;
                end else if (tmo_term_s) begin
                    state_nx_s  = HOLD;
                    ready_nx_s  = 1'b1;
                    check_set_s = 1'b1;
                    tmo_clr_s   = 1'b1;
                end else begin
                    ready_nx_s = 1'b0;
                    tmo_en_s   = 1'b1;
                end
            end
            HOLD: begin
                ready_nx_s = 1'b1;
                if (any_strobe_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = HOLD;
                end
            end
            default: begin
                state_nx_s = IDLE;
                ready_nx_s = 1'b1;
                cnt_clr_s  = 1'b1;
                tmo_clr_s  = 1'b1;
            end
        endcase
    end

    // State, registered outputs and strobe history; a timeout set beats check_clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r           <= IDLE;
            ready_r           <= 1'b1;
            check_r           <= 1'b0;
            prev_any_strobe_r <= 1'b1;
        end else begin
            state_r           <= state_nx_s;
            ready_r           <= ready_nx_s;
            prev_any_strobe_r <= any_strobe_s;
            if (check_set_s) begin
                check_r <= 1'b1;
            end else if (bus.check_clear) begin
                check_r <= 1'b0;
            end else begin
                check_r <= check_r;
            end
        end
    end

    assign bus.io_channel_ready = ready_r;
    assign bus.io_channel_check = check_r;

endmodule
